// File: rtl/inst_mem.sv
// inst_mem: fetch-stage instruction memory with a byte-serial program loader.
// Fetches return the addressed word one cycle after ce; the loader writes a
// big-endian byte stream into consecutive words starting at word 0.
module inst_mem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        addr_err,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        busy,
    output logic        ld_overflow
);

    // state | meaning
    // SERVE | fetches answered from RAM, loader idle
    // LOAD  | accepting loader bytes, fetch outputs forced to NOP/invalid
    // FLUSH | one cycle after the final write before fetches resume
    typedef enum logic [1:0] {
        SERVE = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    state_t                state_q;
    logic [31:0]           rd_q;
    logic                  hit_q;
    logic                  inst_valid_q;
    logic                  addr_err_q;
    logic                  ld_ready_q;
    logic                  busy_q;
    logic                  ovf_q;
    logic [1:0]            cnt_q;
    logic [31:0]           buf_q;
    logic [31:0]           buf_d;
    logic [DEPTH_LOG2:0]   ptr_q;
    logic [DEPTH_LOG2:0]   ptr_d;
    logic                  ld_acc;
    logic                  wr_word;
    logic                  wr_en;
    logic [31:0]           wdata;
    logic                  fetch_bad;
    logic [DEPTH_LOG2-1:0] fetch_idx;

    // ld_ready_q is high exactly while in LOAD, so it doubles as the accept qualifier.
    assign ld_acc    = ld_ready_q && ld_valid;
    // New byte lands at bits 31:24 for the first byte down to 7:0 for the fourth;
    // unfilled low bytes stay zero, which gives the padding on a short last word.
    assign wdata     = buf_q | (32'(ld_byte) << {~cnt_q, 3'b000});
    assign wr_word   = ld_acc && ((cnt_q == 2'd3) || ld_last);
    // The pointer MSB marks "past the end": such writes are dropped.
    assign wr_en     = wr_word && !ptr_q[DEPTH_LOG2] && !rst;
    assign buf_d     = (cnt_q == 2'd3) ? '0 : wdata;
    assign ptr_d     = ptr_q[DEPTH_LOG2] ? ptr_q : ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
    assign fetch_idx = addr[DEPTH_LOG2+1:2];
    assign fetch_bad = (addr[1:0] != 2'b00) || (addr[31:DEPTH_LOG2+2] != '0);

    assign inst        = hit_q ? rd_q : '0;
    assign inst_valid  = inst_valid_q;
    assign addr_err    = addr_err_q;
    assign ld_ready    = ld_ready_q;
    assign busy        = busy_q;
    assign ld_overflow = ovf_q;

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q[DEPTH_LOG2-1:0]] <= wdata;
        end
    end

    // RAM read port; output selection is done by hit_q so this stays a plain RAM read.
    always_ff @(posedge clk) begin
        if (ce && (state_q == SERVE)) begin
            rd_q <= mem[fetch_idx];
        end
    end

    // Sequencer: fetch response flags, loader handshake, byte assembly and pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SERVE;
            hit_q        <= 1'b0;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            ld_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
            buf_q        <= '0;
            ptr_q        <= '0;
        end else begin
            case (state_q)
                SERVE: begin
                    if (ld_start) begin
                        state_q      <= LOAD;
                        ld_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        ovf_q        <= 1'b0;
                        cnt_q        <= '0;
                        buf_q        <= '0;
                        ptr_q        <= '0;
                        hit_q        <= 1'b0;
                        inst_valid_q <= 1'b0;
                        addr_err_q   <= 1'b0;
                    end else begin
                        hit_q        <= ce && !fetch_bad;
                        inst_valid_q <= ce;
                        addr_err_q   <= ce && fetch_bad;
                    end
                end
                LOAD: begin
                    hit_q        <= 1'b0;
                    inst_valid_q <= 1'b0;
                    addr_err_q   <= 1'b0;
                    if (ld_acc) begin
                        cnt_q <= cnt_q + 2'd1;
                        buf_q <= buf_d;
                        if (wr_word) begin
                            if (ptr_q[DEPTH_LOG2]) begin
                                ovf_q <= 1'b1;
                            end
                            ptr_q <= ptr_d;
                        end
                        if (ld_last) begin
                            state_q    <= FLUSH;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state_q <= SERVE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= SERVE;
                    ld_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem.sv
// Bench for inst_mem: a large (1024-word) and a tiny (4-word) instance share one
// stimulus stream and are each compared against a word-level reference model.
module tb_inst_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce, ld_start, ld_valid, ld_last;
    logic [31:0] addr;
    logic [7:0]  ld_byte;
    logic [31:0] inst_b, inst_s;
    logic        iv_b, iv_s, err_b, err_s, rdy_b, rdy_s, busy_b, busy_s, ovf_b, ovf_s;

    inst_mem #(.DEPTH_LOG2(10)) dut_big (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr),
        .inst(inst_b), .inst_valid(iv_b), .addr_err(err_b),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(rdy_b), .busy(busy_b), .ld_overflow(ovf_b)
    );

    inst_mem #(.DEPTH_LOG2(2)) dut_sml (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr),
        .inst(inst_s), .inst_valid(iv_s), .addr_err(err_s),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(rdy_s), .busy(busy_s), .ld_overflow(ovf_s)
    );

    typedef logic [7:0] bq_t[$];

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model: word images and "has been written" flags per instance.
    logic [31:0] m_b [1024];
    bit          k_b [1024];
    logic [31:0] m_s [4];
    bit          k_s [4];
    bit          movf_b = 1'b0;
    bit          movf_s = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Commit an image: every group of four bytes is one big-endian word; a short
    // tail is zero-padded when complete=1, discarded otherwise (aborted load).
    task automatic apply_image(input bq_t bytes, input int n, input bit complete);
        int nw;
        logic [31:0] w;
        nw = complete ? (n + 3) / 4 : n / 4;
        for (int wi = 0; wi < nw; wi++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                w = {w[23:0], ((4 * wi + j) < n) ? bytes[4 * wi + j] : 8'h00};
            end
            if (wi < 1024) begin m_b[wi] = w; k_b[wi] = 1'b1; end
            if (wi < 4)    begin m_s[wi] = w; k_s[wi] = 1'b1; end
        end
        movf_b = complete && (nw > 1024);
        movf_s = complete && (nw > 4);
    endtask

    task automatic check_ctrl(input string tag, input bit rdy, input bit bsy);
        chk({tag, "_iv_b"},   iv_b,   32'd0);
        chk({tag, "_iv_s"},   iv_s,   32'd0);
        chk({tag, "_err_b"},  err_b,  32'd0);
        chk({tag, "_err_s"},  err_s,  32'd0);
        chk({tag, "_inst_b"}, inst_b, 32'd0);
        chk({tag, "_inst_s"}, inst_s, 32'd0);
        chk({tag, "_rdy_b"},  rdy_b,  32'(rdy));
        chk({tag, "_rdy_s"},  rdy_s,  32'(rdy));
        chk({tag, "_busy_b"}, busy_b, 32'(bsy));
        chk({tag, "_busy_s"}, busy_s, 32'(bsy));
    endtask

    task automatic fetch(input string tag, input logic [31:0] a, input bit c);
        bit in_b, in_s;
        ce = c; addr = a; ld_start = 1'b0;
        ld_valid = 1'($urandom); ld_byte = 8'($urandom); ld_last = 1'($urandom);
        step();
        in_b = (a[1:0] == 2'b00) && (a < 32'd4096);
        in_s = (a[1:0] == 2'b00) && (a < 32'd16);
        chk({tag, "_iv_b"},  iv_b,  32'(c));
        chk({tag, "_iv_s"},  iv_s,  32'(c));
        chk({tag, "_err_b"}, err_b, 32'(c && !in_b));
        chk({tag, "_err_s"}, err_s, 32'(c && !in_s));
        if (!(c && in_b))      chk({tag, "_inst_b"}, inst_b, 32'd0);
        else if (k_b[a[11:2]]) chk({tag, "_inst_b"}, inst_b, m_b[a[11:2]]);
        if (!(c && in_s))      chk({tag, "_inst_s"}, inst_s, 32'd0);
        else if (k_s[a[3:2]])  chk({tag, "_inst_s"}, inst_s, m_s[a[3:2]]);
    endtask

    // Full load sequence with random valid gaps, stray ld_start and fetch traffic.
    // abort_at >= 0 asserts rst instead of presenting byte number abort_at.
    task automatic load(input string tag, input bq_t bytes, input int abort_at,
                        input int gap_pct, input bit ce_at_start);
        int  i;
        bit  v;
        int  n;
        n = bytes.size();
        ld_start = 1'b1; ce = ce_at_start; addr = 32'($urandom_range(0, 3)) << 2;
        ld_valid = 1'b1; ld_byte = 8'hEE; ld_last = 1'b1;
        step();
        check_ctrl({tag, "_start"}, 1'b1, 1'b1);
        chk({tag, "_start_ovf_b"}, ovf_b, 32'd0);
        chk({tag, "_start_ovf_s"}, ovf_s, 32'd0);
        i = 0;
        while (i < n) begin
            if (abort_at == i) begin
                rst = 1'b1; ld_valid = 1'b0; ld_start = 1'b0; ce = 1'b0;
                step();
                rst = 1'b0;
                check_ctrl({tag, "_abort"}, 1'b0, 1'b0);
                chk({tag, "_abort_ovf_b"}, ovf_b, 32'd0);
                chk({tag, "_abort_ovf_s"}, ovf_s, 32'd0);
                apply_image(bytes, i, 1'b0);
                return;
            end
            v = ($urandom_range(0, 99) >= gap_pct);
            ld_valid = v;
            ld_byte  = v ? bytes[i] : 8'($urandom);
            ld_last  = v ? (i == n - 1) : 1'($urandom);
            ld_start = ($urandom_range(0, 9) == 0);
            ce       = 1'($urandom);
            addr     = 32'($urandom_range(0, 3)) << 2;
            step();
            if (v) i++;
            if (v && (i == n)) check_ctrl({tag, "_flush"}, 1'b0, 1'b1);
            else               check_ctrl({tag, "_load"},  1'b1, 1'b1);
        end
        ld_valid = 1'b0; ld_last = 1'b0; ce = 1'b0;
        ld_start = 1'($urandom);
        step();
        ld_start = 1'b0;
        check_ctrl({tag, "_done"}, 1'b0, 1'b0);
        apply_image(bytes, n, 1'b1);
        chk({tag, "_ovf_b"}, ovf_b, 32'(movf_b));
        chk({tag, "_ovf_s"}, ovf_s, 32'(movf_s));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t         q;
        logic [31:0] a;
        int          sel;

        rst = 1'b1; ce = 1'b1; addr = '0; ld_start = 1'b0;
        ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
        step();
        check_ctrl("reset", 1'b0, 1'b0);
        chk("reset_ovf_b", ovf_b, 32'd0);
        chk("reset_ovf_s", ovf_s, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fetch("idle", $urandom, 1'b0);
            chk("idle_busy", busy_b, 32'd0);
            chk("idle_rdy",  rdy_b,  32'd0);
        end

        q = '{8'h34, 8'h01, 8'h00, 8'h01, 8'h24, 8'h02, 8'h00, 8'h02};
        load("img1", q, -1, 0, 1'b0);
        fetch("img1_f0", 32'h0, 1'b1);
        chk("img1_w0", inst_b, 32'h34010001);
        fetch("img1_f4", 32'h4, 1'b1);
        chk("img1_w1", inst_b, 32'h24020002);

        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        load("img2", q, -1, 30, 1'b1);
        fetch("img2_f4", 32'h4, 1'b1);
        chk("img2_w1", inst_s, 32'h11220000);
        fetch("img2_f0", 32'h0, 1'b1);
        chk("img2_w0", inst_b, 32'hAABBCCDD);

        fetch("mis", 32'h0000_0002, 1'b1);
        fetch("oor", 32'h0000_1000, 1'b1);
        fetch("after_oor", 32'h0000_1000, 1'b0);
        fetch("sml_oor", 32'h0000_0010, 1'b1);
        fetch("hi_bit", 32'h8000_0000, 1'b1);

        q.delete();
        for (int k = 0; k < 20; k++) q.push_back(8'($urandom));
        load("img3", q, -1, 25, 1'b0);
        fetch("img3_fc", 32'hC, 1'b1);
        fetch("img3_f10", 32'h10, 1'b1);
        chk("img3_ovf_s_sticky", ovf_s, 32'd1);
        chk("img3_ovf_b_clear",  ovf_b, 32'd0);

        q.delete();
        for (int k = 0; k < 4 * 1024 + 5; k++) q.push_back(8'($urandom));
        load("img4", q, -1, 20, 1'b1);
        fetch("img4_top", 32'hFFC, 1'b1);
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 99);
            if (sel < 80)      a = 32'($urandom_range(0, 1023)) << 2;
            else if (sel < 90) a = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
            else               a = $urandom;
            fetch("rnd", a, ($urandom_range(0, 9) != 0));
        end
        chk("img4_ovf_b_sticky", ovf_b, 32'd1);

        q.delete();
        for (int k = 0; k < 12; k++) q.push_back(8'($urandom));
        load("img5", q, 6, 20, 1'b0);
        fetch("img5_f0", 32'h0, 1'b1);
        fetch("img5_f4", 32'h4, 1'b1);
        fetch("img5_f8", 32'h8, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_mem.md
# inst_mem

Instruction-memory responder for the fetch stage: accepts the fetch address and chip enable driven by the PC register and returns the 32-bit instruction word one cycle later. Word storage is a synchronous RAM preloaded after reset through a byte-serial loader port (big-endian, MIPS byte order). It sits between the PC register and the IF/ID pipeline register and replaces a pure combinational ROM, so program images can be loaded by the bench or a boot controller without recompiling.

## Interface

- DEPTH_LOG2, 10, log2 of word count (1024 words, byte span 4·2^DEPTH_LOG2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- ce  in  1  fetch chip enable from PC register
- addr  in  32  fetch byte address
- inst  out  32  instruction word
- inst_valid  out  1  inst holds a valid fetched word
- addr_err  out  1  one-cycle pulse: misaligned or out-of-range fetch
- ld_start  in  1  pulse: begin program load at word 0
- ld_valid  in  1  loader byte valid
- ld_byte  in  8  loader data byte
- ld_last  in  1  qualifies final byte of image
- ld_ready  out  1  loader may present a byte
- busy  out  1  load in progress, fetch not served
- ld_overflow  out  1  sticky: image exceeded DEPTH words

## Operation

- Reset (synchronous, active-high): state SERVE; inst=0, inst_valid=0, addr_err=0, ld_ready=0, busy=0, ld_overflow=0; byte counter and word pointer 0. RAM contents retained.
- States: SERVE, LOAD, FLUSH.
- SERVE: if ld_start=1 -> LOAD (clear byte counter, word pointer, ld_overflow). Else fetch service:
  - ce=0: next inst=0, inst_valid=0, addr_err=0.
  - ce=1, addr[1:0]≠0 or addr[31:DEPTH_LOG2+2]≠0: next inst=0 (NOP), inst_valid=1, addr_err=1.
  - ce=1, otherwise: next inst=mem[addr[DEPTH_LOG2+1:2]], inst_valid=1, addr_err=0.
- LOAD: ld_ready=1, busy=1; fetch outputs forced inst=0, inst_valid=0, addr_err=0 regardless of ce. Byte accepted when ld_valid&ld_ready. Bytes assemble big-endian: first byte -> bits 31:24, fourth -> 7:0. On 4th byte: write word at pointer, pointer+1, counter 0. Accepted byte with ld_last=1: if it completes a word, write normally; else zero-pad remaining low bytes and write; then -> FLUSH.
- Overflow: write when pointer = 2^DEPTH_LOG2 is dropped, ld_overflow set; pointer saturates (no wrap). Load continues to ld_last.
- FLUSH: one cycle, ld_ready=0, busy=1, -> SERVE. Guarantees last write committed before any read.
- ld_start in LOAD/FLUSH ignored. ld_valid in SERVE ignored (ld_ready=0).
- Reset mid-load: abort immediately to SERVE; words already written persist, partial word discarded.

## Timing

- Fetch latency 1 cycle: ce/addr sampled at edge N, inst/inst_valid/addr_err valid after edge N, held until edge N+1. Back-to-back fetches each cycle, no stalls.
- Same-cycle ld_start and ce=1 in SERVE: load wins; that fetch returns inst_valid=0.
- Load throughput: one byte per cycle; 4 cycles per word; last write at the ld_last edge; SERVE two edges after ld_last accepted.
- busy asserts the cycle after ld_start, deasserts on return to SERVE.
- Write and read never coincide (fetch blocked in LOAD/FLUSH); single-port RAM sufficient.

## Test plan

- Reset then ce=0 -> inst=0, inst_valid=0, ld_ready=0, busy=0 for all cycles.
- Load bytes 34 01 00 01 24 02 00 02 with ld_last on final -> mem[0]=0x34010001, mem[1]=0x24020002; fetch addr 0x0 then 0x4 back-to-back -> same words one cycle after each, inst_valid=1.
- Load 6 bytes AA BB CC DD 11 22 (ld_last on 22) -> mem[1]=0x11220000, mem[0]=0xAABBCCDD.
- Fetch addr 0x00000002 and 0x00001000 (DEPTH_LOG2=10) -> inst=0, inst_valid=1, addr_err one-cycle pulse each.
- DEPTH_LOG2=2: load 5 words -> words 0–3 written, 5th dropped, ld_overflow=1 until next ld_start; fetch 0xC returns word 3.
- rst asserted after 2 bytes of second word -> SERVE next cycle, mem[0] from first word intact, busy=0, ld_ready=0.
